// File: rtl/me_min_sad_select.sv
// Minimum-SAD selector for the motion-estimation path: walks a RANGE x RANGE
// search window in raster order, keeps the lowest SAD and its motion vector.
module me_min_sad_select #(
   parameter int RANGE = 8,
   parameter int SAD_W = 8,
   parameter int MV_W  = $clog2(RANGE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sad_valid,
   input  logic [SAD_W-1:0] sad,
   output logic             roll,
   output logic             busy,
   output logic             done,
   output logic [SAD_W-1:0] best_sad,
   output logic [MV_W-1:0]  best_x,
   output logic [MV_W-1:0]  best_y
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [MV_W-1:0] LAST_POS = MV_W'(RANGE - 1);

   state_t          state;
   logic [MV_W-1:0] cur_x;
   logic [MV_W-1:0] cur_y;
   logic            first;
   logic            take;

   // The first candidate of every search loads unconditionally; after that a
   // strict less-than keeps the earliest candidate on ties.
   assign take = first || (sad < best_sad);

   // NOTE: every register here is state, so all assignments are non-blocking;
   // mixing in blocking writes would make the update order simulation-dependent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         roll     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         best_sad <= '0;
         best_x   <= '0;
         best_y   <= '0;
         cur_x    <= '0;
         cur_y    <= '0;
         first    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= SEARCH;
                  busy  <= 1'b1;
                  roll  <= 1'b1;
                  cur_x <= '0;
                  cur_y <= '0;
                  first <= 1'b1;
               end
            end

            SEARCH: begin
               if (sad_valid) begin
                  if (take) begin
                     best_sad <= sad;
                     best_x   <= cur_x;
                     best_y   <= cur_y;
                  end
                  first <= 1'b0;
                  if (cur_x == LAST_POS) begin
                     cur_x <= '0;
                     if (cur_y == LAST_POS) begin
                        // Last candidate of the window: result is final now.
                        cur_y <= '0;
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        roll  <= 1'b0;
                     end else begin
                        cur_y <= cur_y + 1'b1;
                     end
                  end else begin
                     cur_x <= cur_x + 1'b1;
                  end
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               roll  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_me_min_sad_select.sv
// Directed bench for me_min_sad_select with RANGE=4; expectations are the
// hand-computed results of each stimulus table.
module tb_me_min_sad_select;

   localparam int RANGE = 4;
   localparam int SAD_W = 8;
   localparam int MV_W  = 2;

   logic             clk;
   logic             rst;
   logic             start;
   logic             sad_valid;
   logic [SAD_W-1:0] sad;
   logic             roll;
   logic             busy;
   logic             done;
   logic [SAD_W-1:0] best_sad;
   logic [MV_W-1:0]  best_x;
   logic [MV_W-1:0]  best_y;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int busy_seen = 0;
   logic [7:0] sads [16];

   me_min_sad_select #(.RANGE(RANGE), .SAD_W(SAD_W), .MV_W(MV_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sad_valid(sad_valid),
      .sad      (sad),
      .roll     (roll),
      .busy     (busy),
      .done     (done),
      .best_sad (best_sad),
      .best_x   (best_x),
      .best_y   (best_y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (busy || roll) busy_seen++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Runs one search from IDLE using sads[]; returns the number of cycles
   // from the start cycle to the cycle showing done (inclusive).
   task automatic run_search(input bit bubble, input int start_at, input bit start_in_done,
                             output int cycles);
      int n;
      bit early_done;
      early_done = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      check("busy_after_start", {30'd0, busy, roll}, 32'd3);
      for (int i = 0; i < 16; i++) begin
         if (bubble) begin
            sad_valid = 1'b0;
            sad = 8'hxx;
            @(negedge clk);
            n++;
            if (done) early_done = 1;
         end
         sad_valid = 1'b1;
         sad = sads[i];
         start = (i == start_at);
         @(negedge clk);
         n++;
         start = 1'b0;
         if (i < 15 && done) early_done = 1;
      end
      sad_valid = 1'b0;
      check("no_early_done", {31'd0, early_done}, 32'd0);
      check("done_pulse", {31'd0, done}, 32'd1);
      check("idle_in_done", {30'd0, busy, roll}, 32'd0);
      cycles = n;
      start = start_in_done;
      @(negedge clk);
      start = 1'b0;
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("idle_after_done", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int cyc;
      rst = 1'b1;
      start = 1'b0;
      sad_valid = 1'b0;
      sad = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset / idle
      busy_seen = 0;
      repeat (10) @(negedge clk);
      check("idle_busy_seen", busy_seen, 0);
      check("idle_done", {31'd0, done}, 32'd0);
      check("idle_best_sad", best_sad, 0);
      check("idle_best_xy", {best_y, best_x}, 0);

      // Unique minimum at raster index 9 -> (x=1, y=2)
      for (int i = 0; i < 16; i++) sads[i] = 8'd200;
      sads[9] = 8'd17;
      done_cnt = 0;
      run_search(1'b0, -1, 1'b0, cyc);
      check("uniq_latency", cyc, 17);
      check("uniq_best_sad", best_sad, 17);
      check("uniq_best_x", best_x, 1);
      check("uniq_best_y", best_y, 2);
      check("uniq_done_cnt", done_cnt, 1);

      // Ties at indices 3 and 12 with a bubble before every sample
      for (int i = 0; i < 16; i++) sads[i] = 8'd90;
      sads[3] = 8'd50;
      sads[12] = 8'd50;
      done_cnt = 0;
      run_search(1'b1, -1, 1'b0, cyc);
      check("tie_latency", cyc, 33);
      check("tie_best_sad", best_sad, 50);
      check("tie_best_x", best_x, 3);
      check("tie_best_y", best_y, 0);
      check("tie_done_cnt", done_cnt, 1);

      // Back-to-back: minimum 5 at index 6, then an all-255 search
      for (int i = 0; i < 16; i++) sads[i] = 8'd40 + 8'(i);
      sads[6] = 8'd5;
      run_search(1'b0, -1, 1'b0, cyc);
      check("b2b1_best_sad", best_sad, 5);
      check("b2b1_best_xy", {best_y, best_x}, {2'd1, 2'd2});
      for (int i = 0; i < 16; i++) sads[i] = 8'd255;
      run_search(1'b0, -1, 1'b0, cyc);
      check("b2b2_best_sad", best_sad, 255);
      check("b2b2_best_x", best_x, 0);
      check("b2b2_best_y", best_y, 0);

      // Ignored start at candidate 7 and in the DONE cycle
      for (int i = 0; i < 16; i++) sads[i] = 8'd100 + 8'(i);
      sads[14] = 8'd30;
      done_cnt = 0;
      run_search(1'b0, 7, 1'b1, cyc);
      check("ign_latency", cyc, 17);
      repeat (3) @(negedge clk);
      check("ign_done_cnt", done_cnt, 1);
      check("ign_idle", {30'd0, busy, roll}, 32'd0);
      check("ign_best_sad", best_sad, 30);
      check("ign_best_xy", {best_y, best_x}, {2'd3, 2'd2});

      // Reset after 10 candidates
      for (int i = 0; i < 16; i++) sads[i] = 8'd200;
      done_cnt = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sad_valid = 1'b1;
         sad = sads[i];
         @(negedge clk);
      end
      sad_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_async_busy", {30'd0, busy, roll}, 32'd0);
      check("rst_async_best", {16'd0, best_sad, 4'd0, best_y, best_x}, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("rst_no_done", done_cnt, 0);
      check("rst_stays_idle", {31'd0, busy}, 32'd0);

      // Fresh search after reset
      for (int i = 0; i < 16; i++) sads[i] = 8'd150 - 8'(i);
      run_search(1'b0, -1, 1'b0, cyc);
      check("post_rst_latency", cyc, 17);
      check("post_rst_best_sad", best_sad, 135);
      check("post_rst_best_xy", {best_y, best_x}, {2'd3, 2'd3});
      check("post_rst_done_cnt", done_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
